gestor_solicitudes: RTL

- Request memory stage sitting directly upstream of the elevator state machine, between the button encoder and the FSM.
- Latches every hall and car call as a pending request and clears calls served when the doors open.
- Publishes on memoria a single 4-bit target code (0..10), chosen by a direction-preserving (SCAN) policy, which the FSM consumes once per step.
- Holds memoria stable while the FSM samples it (LE=0).

---
 rtl/gestor_solicitudes_if.sv | 22 ++
 rtl/gestor_solicitudes.sv | 132 +++++++++++++
 2 files changed

// File: rtl/gestor_solicitudes_if.sv
// Request-memory bus between the button encoder / elevator FSM and gestor_solicitudes.
// Carries the FSM handshake (LE, floor, motion, doors) and the published target code.
interface gestor_solicitudes_if;
  logic       LE;
  logic       puertas;
  logic [1:0] accion;
  logic [1:0] piso;
  logic [3:0] boton_pres;
  logic [3:0] memoria;
  logic [9:0] pendientes;
  logic       dir;

  modport master (
    output LE, puertas, accion, piso, boton_pres,
    input  memoria, pendientes, dir
  );

  modport slave (
    input  LE, puertas, accion, piso, boton_pres,
    output memoria, pendientes, dir
  );
endinterface

// File: rtl/gestor_solicitudes.sv
// Pending-request memory for the elevator: latches hall/car calls, clears served floors,
// and publishes one SCAN-ordered target code per LE step.
module gestor_solicitudes #(
  parameter int unsigned EDGE_CAPTURE = 1
) (
  input logic               clk,
  input logic               rst,
  gestor_solicitudes_if.slave bus
);

  localparam int unsigned NUM_CODES  = 10;
  localparam int unsigned CODE_W     = 4;
  localparam int unsigned FLOOR_W    = 2;
  localparam int unsigned NUM_FLOORS = 4;

  logic [NUM_CODES-1:0] pend_q, pend_d;
  logic [CODE_W-1:0]    mem_q, mem_d;
  logic [CODE_W-1:0]    prev_q;
  logic                 dir_q, dir_d;

  logic [NUM_CODES-1:0] set_mask, clear_mask;
  logic                 code_ok, new_press;

  logic [NUM_FLOORS-1:0]             floor_any;
  logic [NUM_FLOORS-1:0][CODE_W-1:0] low_code;
  logic                              above_any, below_any;
  logic [CODE_W-1:0]                 above_code, below_code;

  // Floor served by pending bit idx (bit idx holds code idx+1).
  function automatic logic [FLOOR_W-1:0] floor_of(input logic [CODE_W-1:0] idx);
    case (idx)
      4'd0, 4'd4:       floor_of = 2'd0;
      4'd1, 4'd5, 4'd6: floor_of = 2'd1;
      4'd2, 4'd7, 4'd8: floor_of = 2'd2;
      default:          floor_of = 2'd3;
    endcase
  endfunction

  // Capture and clear masks; clear is applied last so it wins on the same floor.
  always_comb begin
    code_ok   = (bus.boton_pres != 4'd0) && (bus.boton_pres <= 4'd10);
    new_press = (EDGE_CAPTURE == 0) || (bus.boton_pres != prev_q);
    set_mask  = '0;
    if (code_ok && new_press) begin
      set_mask = NUM_CODES'(1) << (bus.boton_pres - 4'd1);
    end
    clear_mask = '0;
    for (int i = 0; i < int'(NUM_CODES); i++) begin
      clear_mask[4'(i)] = bus.puertas && (floor_of(4'(i)) == bus.piso);
    end
    pend_d = (pend_q | set_mask) & ~clear_mask;
  end

  // Per-floor occupancy and lowest code, then nearest occupied floor above/below piso.
  always_comb begin
    floor_any  = '0;
    low_code   = '0;
    above_any  = 1'b0;
    above_code = '0;
    below_any  = 1'b0;
    below_code = '0;
    for (int i = int'(NUM_CODES) - 1; i >= 0; i--) begin
      if (pend_q[4'(i)]) begin
        floor_any[floor_of(4'(i))] = 1'b1;
        low_code[floor_of(4'(i))]  = 4'(i + 1);
      end
    end
    for (int f = int'(NUM_FLOORS) - 1; f >= 0; f--) begin
      if ((f > int'(bus.piso)) && floor_any[2'(f)]) begin
        above_any  = 1'b1;
        above_code = low_code[2'(f)];
      end
    end
    for (int f = 0; f < int'(NUM_FLOORS); f++) begin
      if ((f < int'(bus.piso)) && floor_any[2'(f)]) begin
        below_any  = 1'b1;
        below_code = low_code[2'(f)];
      end
    end
  end

  // Target selection; a scan turnaround overrides the accion direction seed.
  always_comb begin
    mem_d = mem_q;
    dir_d = dir_q;
    case (bus.accion)
      2'd1:    dir_d = 1'b0;
      2'd2:    dir_d = 1'b1;
      default: dir_d = dir_q;
    endcase
    if (bus.LE) begin
      if (pend_q == '0) begin
        mem_d = '0;
      end else if (floor_any[bus.piso]) begin
        mem_d = low_code[bus.piso];
      end else if (!dir_q) begin
        if (above_any) begin
          mem_d = above_code;
        end else begin
          mem_d = below_code;
          dir_d = 1'b1;
        end
      end else begin
        if (below_any) begin
          mem_d = below_code;
        end else begin
          mem_d = above_code;
          dir_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      mem_q  <= '0;
      dir_q  <= 1'b0;
      prev_q <= '0;
    end else begin
      pend_q <= pend_d;
      mem_q  <= mem_d;
      dir_q  <= dir_d;
      prev_q <= bus.boton_pres;
    end
  end

  assign bus.pendientes = pend_q;
  assign bus.memoria    = mem_q;
  assign bus.dir        = dir_q;

endmodule
